// File: rtl/cpu_defs.sv
`default_nettype none
// ============================================================================
// Module      : cpu_defs (package)
// Description : Shared definitions for the 5-stage MIPS pipeline hazard unit.
//               Provides the forwarding-select encoding, Tuse/Tnew limits, the
//               per-stage producer record and helpers to qualify and age it.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_defs;

    // Widths of the fields carried in every stage record.
    localparam int REC_RA_W = 5;
    localparam int REC_T_W  = 2;

    // Forwarding mux select encoding.
    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    // Tuse value marking an operand that is never read, and the largest Tnew
    // any instruction can report.
    localparam logic [REC_T_W-1:0] TUSE_NONE = 2'd3;
    localparam logic [REC_T_W-1:0] TNEW_MAX  = 2'd2;

    // Producer information kept for the instruction sitting in E, M or W.
    typedef struct packed {
        logic [REC_RA_W-1:0] a3;
        logic                regwrite;
        logic [REC_T_W-1:0]  tnew;
    } stage_rec_t;

    // Only a writing instruction with a non-zero destination can produce a
    // value; $0 is hard-wired and must never stall or forward.
    function automatic logic is_producer(input stage_rec_t rec);
        return rec.regwrite && (rec.a3 != '0);
    endfunction

    // Saturating decrement: once a result is ready it stays ready.
    function automatic logic [REC_T_W-1:0] sat_dec(input logic [REC_T_W-1:0] t);
        return (t == '0) ? '0 : (t - REC_T_W'(1));
    endfunction

    // Record as it appears one stage further down the pipe.
    function automatic stage_rec_t advance(input stage_rec_t rec);
        stage_rec_t nxt;
        nxt          = rec;
        nxt.tnew     = sat_dec(rec.tnew);
        return nxt;
    endfunction

endpackage : cpu_defs
`default_nettype wire

// File: rtl/hazard_fwd_sel.sv
`default_nettype none
// ============================================================================
// Module      : hazard_fwd_sel
// Description : Combinational nearest-first forwarding select for a single
//               source operand. Scans an ordered list of stage records
//               (index 0 = youngest/nearest) and returns the select code of
//               the first record that writes the operand, provided that
//               record's result is already available (tnew == 0).
//               A matching record whose result is not yet ready still wins
//               the priority scan, so older stages can never supply a stale
//               value; the select then stays FWD_RF.
// Ports       : operand - register address being read
//               srcs    - candidate producer records, nearest first
//               sel     - forwarding select (FWD_RF when nothing qualifies)
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_fwd_sel
    import cpu_defs::*;
#(
    parameter int                 N_SRC     = 3,
    parameter logic [2*N_SRC-1:0] SRC_CODES = {FWD_W, FWD_M, FWD_E}
) (
    input  logic [REC_RA_W-1:0]    operand,
    input  stage_rec_t [N_SRC-1:0] srcs,
    output logic [1:0]             sel
);

    // Set once the nearest writer of the operand has been seen.
    logic w_claimed;

    always_comb begin
        sel       = FWD_RF;
        w_claimed = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (!w_claimed && is_producer(srcs[i]) && (srcs[i].a3 == operand)) begin
                w_claimed = 1'b1;
                if (srcs[i].tnew == '0) begin
                    sel = SRC_CODES[2*i +: 2];
                end
            end
        end
    end

endmodule : hazard_fwd_sel
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Hazard unit for the F/D/E/M/W MIPS pipeline. Keeps a producer
//               record for the instructions in E, M and W, raises the D-stage
//               stall (with an E-stage bubble) when a D operand is needed
//               before its producer can deliver it, and drives every
//               forwarding mux select in the datapath.
// Ports       : clk          - system clock, rising edge
//               reset        - asynchronous active-high, clears all records
//               d_rs, d_rt   - source register fields of the D instruction
//               d_rs_tuse    - cycles until rs is consumed (3 = not read)
//               d_rt_tuse    - cycles until rt is consumed (3 = not read)
//               d_tnew       - cycles from E entry until the result exists
//               d_a3         - destination register of the D instruction
//               d_regwrite   - D instruction writes the register file
//               stall        - freeze PC/D register, bubble into E
//               fwd_d_rs/rt  - D operand source: 0 GRF, 1 E, 2 M, 3 W
//               fwd_e_rs/rt  - E operand source: 0 pipe reg, 2 M, 3 W
//               fwd_m_rt     - M store-data source: 0 pipe reg, 1 W
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import cpu_defs::*;
#(
    // Must match the record widths in cpu_defs.
    parameter int RA_W = REC_RA_W,
    parameter int T_W  = REC_T_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [RA_W-1:0] d_rs,
    input  logic [RA_W-1:0] d_rt,
    input  logic [T_W-1:0]  d_rs_tuse,
    input  logic [T_W-1:0]  d_rt_tuse,
    input  logic [T_W-1:0]  d_tnew,
    input  logic [RA_W-1:0] d_a3,
    input  logic            d_regwrite,
    output logic            stall,
    output logic [1:0]      fwd_d_rs,
    output logic [1:0]      fwd_d_rt,
    output logic [1:0]      fwd_e_rs,
    output logic [1:0]      fwd_e_rt,
    output logic            fwd_m_rt
);

    // ------------------------------------------------------------------------
    // Stage records
    // ------------------------------------------------------------------------
    stage_rec_t      r_e;
    stage_rec_t      r_m;
    stage_rec_t      r_w;
    logic [RA_W-1:0] r_e_rs;
    logic [RA_W-1:0] r_e_rt;
    logic [RA_W-1:0] r_m_rt;

    // Record the D instruction turns into when it enters E.
    stage_rec_t      w_d_rec;
    logic [T_W-1:0]  w_d_tnew;

    // An out-of-range Tnew from the decoder is pinned to the maximum so the
    // stall comparison stays meaningful for Tuse values up to 2.
    assign w_d_tnew = (d_tnew > TNEW_MAX) ? TNEW_MAX : d_tnew;

    always_comb begin
        w_d_rec          = '0;
        w_d_rec.a3       = d_a3;
        w_d_rec.regwrite = d_regwrite;
        w_d_rec.tnew     = w_d_tnew;
    end

    // ------------------------------------------------------------------------
    // Stall detection
    // ------------------------------------------------------------------------
    // An operand must wait when a producer in E or M will not have its value
    // ready by the time the operand is consumed. W always has its result, so
    // it is never part of this check.
    function automatic logic op_hazard(
        input logic [RA_W-1:0] op,
        input logic [T_W-1:0]  tuse,
        input stage_rec_t      rec
    );
        return (op != '0) && (tuse != TUSE_NONE) && is_producer(rec) &&
               (rec.a3 == op) && (tuse < rec.tnew);
    endfunction

    logic w_rs_stall;
    logic w_rt_stall;

    assign w_rs_stall = op_hazard(d_rs, d_rs_tuse, r_e) || op_hazard(d_rs, d_rs_tuse, r_m);
    assign w_rt_stall = op_hazard(d_rt, d_rt_tuse, r_e) || op_hazard(d_rt, d_rt_tuse, r_m);
    assign stall      = w_rs_stall || w_rt_stall;

    // ------------------------------------------------------------------------
    // Record pipeline
    // ------------------------------------------------------------------------
    // While stalled the D instruction stays put and E receives a bubble; M and
    // W always advance, ageing tnew by one cycle each step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_e    <= '0;
            r_m    <= '0;
            r_w    <= '0;
            r_e_rs <= '0;
            r_e_rt <= '0;
            r_m_rt <= '0;
        end else begin
            if (stall) begin
                r_e    <= '0;
                r_e_rs <= '0;
                r_e_rt <= '0;
            end else begin
                r_e    <= w_d_rec;
                r_e_rs <= d_rs;
                r_e_rt <= d_rt;
            end
            r_m    <= advance(r_e);
            r_m_rt <= r_e_rt;
            r_w    <= advance(r_m);
        end
    end

    // ------------------------------------------------------------------------
    // Forwarding selects
    // ------------------------------------------------------------------------
    // Candidate lists, nearest stage at index 0.
    stage_rec_t [2:0] w_d_srcs;
    stage_rec_t [1:0] w_e_srcs;
    stage_rec_t [0:0] w_m_srcs;
    logic [1:0]       w_m_rt_sel;

    assign w_d_srcs    = {r_w, r_m, r_e};
    assign w_e_srcs    = {r_w, r_m};
    assign w_m_srcs[0] = r_w;

    hazard_fwd_sel #(
        .N_SRC     (3),
        .SRC_CODES ({FWD_W, FWD_M, FWD_E})
    ) u_fwd_d_rs (
        .operand (d_rs),
        .srcs    (w_d_srcs),
        .sel     (fwd_d_rs)
    );

    hazard_fwd_sel #(
        .N_SRC     (3),
        .SRC_CODES ({FWD_W, FWD_M, FWD_E})
    ) u_fwd_d_rt (
        .operand (d_rt),
        .srcs    (w_d_srcs),
        .sel     (fwd_d_rt)
    );

    hazard_fwd_sel #(
        .N_SRC     (2),
        .SRC_CODES ({FWD_W, FWD_M})
    ) u_fwd_e_rs (
        .operand (r_e_rs),
        .srcs    (w_e_srcs),
        .sel     (fwd_e_rs)
    );

    hazard_fwd_sel #(
        .N_SRC     (2),
        .SRC_CODES ({FWD_W, FWD_M})
    ) u_fwd_e_rt (
        .operand (r_e_rt),
        .srcs    (w_e_srcs),
        .sel     (fwd_e_rt)
    );

    // Store data in M can only be refreshed from W; collapse to one bit.
    hazard_fwd_sel #(
        .N_SRC     (1),
        .SRC_CODES (FWD_W)
    ) u_fwd_m_rt (
        .operand (r_m_rt),
        .srcs    (w_m_srcs),
        .sel     (w_m_rt_sel)
    );

    assign fwd_m_rt = (w_m_rt_sel != FWD_RF);

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. Per-cycle D-stage
//               instruction fields and the expected outputs of that cycle are
//               listed in a table; hand-written sequences cover reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int RA_W = 5;
    localparam int T_W  = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [RA_W-1:0] d_rs;
    logic [RA_W-1:0] d_rt;
    logic [T_W-1:0]  d_rs_tuse;
    logic [T_W-1:0]  d_rt_tuse;
    logic [T_W-1:0]  d_tnew;
    logic [RA_W-1:0] d_a3;
    logic            d_regwrite;
    logic            stall;
    logic [1:0]      fwd_d_rs;
    logic [1:0]      fwd_d_rt;
    logic [1:0]      fwd_e_rs;
    logic [1:0]      fwd_e_rt;
    logic            fwd_m_rt;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .RA_W (RA_W),
        .T_W  (T_W)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_rs_tuse  (d_rs_tuse),
        .d_rt_tuse  (d_rt_tuse),
        .d_tnew     (d_tnew),
        .d_a3       (d_a3),
        .d_regwrite (d_regwrite),
        .stall      (stall),
        .fwd_d_rs   (fwd_d_rs),
        .fwd_d_rt   (fwd_d_rt),
        .fwd_e_rs   (fwd_e_rs),
        .fwd_e_rt   (fwd_e_rt),
        .fwd_m_rt   (fwd_m_rt)
    );

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] rs_tuse;
        logic [1:0] rt_tuse;
        logic [1:0] tnew;
        logic [4:0] a3;
        logic       regwrite;
    } din_t;

    typedef struct packed {
        logic       stall;
        logic [1:0] d_rs;
        logic [1:0] d_rt;
        logic [1:0] e_rs;
        logic [1:0] e_rt;
        logic       m_rt;
    } dout_t;

    typedef struct packed {
        din_t  d;
        dout_t e;
    } vec_t;

    vec_t  tab[$];
    dout_t sb[$];
    int    checks   = 0;
    int    failures = 0;

    // ---------------- instruction field builders ----------------
    function automatic din_t f_nop();
        din_t d = '0;
        d.rs_tuse = 2'd3;
        d.rt_tuse = 2'd3;
        return d;
    endfunction

    function automatic din_t f_lw(input int dst, input int base);
        din_t d = '0;
        d.rs = 5'(base); d.rs_tuse = 2'd1;
        d.rt = 5'(dst);  d.rt_tuse = 2'd3;
        d.tnew = 2'd2; d.a3 = 5'(dst); d.regwrite = 1'b1;
        return d;
    endfunction

    function automatic din_t f_alu(input int dst, input int s, input int t);
        din_t d = '0;
        d.rs = 5'(s); d.rs_tuse = 2'd1;
        d.rt = 5'(t); d.rt_tuse = 2'd1;
        d.tnew = 2'd1; d.a3 = 5'(dst); d.regwrite = 1'b1;
        return d;
    endfunction

    function automatic din_t f_ori(input int dst, input int s);
        din_t d = '0;
        d.rs = 5'(s);   d.rs_tuse = 2'd1;
        d.rt = 5'(dst); d.rt_tuse = 2'd3;
        d.tnew = 2'd1; d.a3 = 5'(dst); d.regwrite = 1'b1;
        return d;
    endfunction

    function automatic din_t f_sw(input int t, input int base);
        din_t d = '0;
        d.rs = 5'(base); d.rs_tuse = 2'd1;
        d.rt = 5'(t);    d.rt_tuse = 2'd2;
        return d;
    endfunction

    function automatic din_t f_beq(input int s, input int t);
        din_t d = '0;
        d.rs = 5'(s); d.rs_tuse = 2'd0;
        d.rt = 5'(t); d.rt_tuse = 2'd0;
        return d;
    endfunction

    function automatic din_t f_jal();
        din_t d = '0;
        d.rs_tuse = 2'd3; d.rt_tuse = 2'd3;
        d.a3 = 5'd31; d.regwrite = 1'b1;
        return d;
    endfunction

    function automatic din_t f_jr(input int s);
        din_t d = '0;
        d.rs = 5'(s); d.rs_tuse = 2'd0;
        d.rt_tuse = 2'd3;
        return d;
    endfunction

    function automatic dout_t mk_out(input int st, input int drs, input int drt,
                                     input int ers, input int ert, input int mrt);
        dout_t o;
        o.stall = 1'(st);
        o.d_rs  = 2'(drs);
        o.d_rt  = 2'(drt);
        o.e_rs  = 2'(ers);
        o.e_rt  = 2'(ert);
        o.m_rt  = 1'(mrt);
        return o;
    endfunction

    function automatic void add(input din_t d, input int st, input int drs, input int drt,
                                input int ers, input int ert, input int mrt);
        vec_t v;
        v.d = d;
        v.e = mk_out(st, drs, drt, ers, ert, mrt);
        tab.push_back(v);
    endfunction

    // ---------------- drive and check ----------------
    task automatic drive(input din_t d);
        d_rs       = d.rs;
        d_rt       = d.rt;
        d_rs_tuse  = d.rs_tuse;
        d_rt_tuse  = d.rt_tuse;
        d_tnew     = d.tnew;
        d_a3       = d.a3;
        d_regwrite = d.regwrite;
    endtask

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    function automatic void chk_all(input string tag, input dout_t exp);
        chk({tag, ".stall"},    int'(stall),    int'(exp.stall));
        chk({tag, ".fwd_d_rs"}, int'(fwd_d_rs), int'(exp.d_rs));
        chk({tag, ".fwd_d_rt"}, int'(fwd_d_rt), int'(exp.d_rt));
        chk({tag, ".fwd_e_rs"}, int'(fwd_e_rs), int'(exp.e_rs));
        chk({tag, ".fwd_e_rt"}, int'(fwd_e_rt), int'(exp.e_rt));
        chk({tag, ".fwd_m_rt"}, int'(fwd_m_rt), int'(exp.m_rt));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        dout_t zero;
        dout_t exp_o;
        zero = '0;

        // lw $8 -> addu $10,$8,$9: stall, bubble, then W forward in E
        add(f_lw(8, 29),      0, 0, 0, 0, 0, 0);
        add(f_alu(10, 8, 9),  1, 0, 0, 0, 0, 0);
        add(f_alu(10, 8, 9),  0, 0, 0, 0, 0, 0);
        add(f_nop(),          0, 0, 0, 3, 0, 0);
        add(f_nop(),          0, 0, 0, 0, 0, 0);
        add(f_nop(),          0, 0, 0, 0, 0, 0);
        // addu $9 -> beq $9: stall, then M forward in D, W forward in E
        add(f_alu(9, 1, 2),   0, 0, 0, 0, 0, 0);
        add(f_beq(9, 0),      1, 0, 0, 0, 0, 0);
        add(f_beq(9, 0),      0, 2, 0, 0, 0, 0);
        add(f_nop(),          0, 0, 0, 3, 0, 0);
        add(f_nop(),          0, 0, 0, 0, 0, 0);
        add(f_nop(),          0, 0, 0, 0, 0, 0);
        // ori $5 -> sw $5: no stall, M forward in E, then W forward in M
        add(f_ori(5, 0),      0, 0, 0, 0, 0, 0);
        add(f_sw(5, 29),      0, 0, 0, 0, 0, 0);
        add(f_nop(),          0, 0, 0, 0, 2, 0);
        add(f_nop(),          0, 0, 0, 0, 0, 1);
        add(f_nop(),          0, 0, 0, 0, 0, 0);
        // lw $0 -> addu rs=$0 rt=$0: never stalls or forwards
        add(f_lw(0, 29),      0, 0, 0, 0, 0, 0);
        add(f_alu(7, 0, 0),   0, 0, 0, 0, 0, 0);
        add(f_nop(),          0, 0, 0, 0, 0, 0);
        add(f_nop(),          0, 0, 0, 0, 0, 0);
        add(f_nop(),          0, 0, 0, 0, 0, 0);
        // addu $3 ; addu $3 ; subu rs=$3: nearest producer wins
        add(f_alu(3, 1, 2),   0, 0, 0, 0, 0, 0);
        add(f_alu(3, 4, 5),   0, 0, 0, 0, 0, 0);
        add(f_alu(6, 3, 10),  0, 0, 0, 0, 0, 0);
        add(f_nop(),          0, 0, 0, 2, 0, 0);
        add(f_nop(),          0, 0, 0, 0, 0, 0);
        add(f_nop(),          0, 0, 0, 0, 0, 0);
        // jal (tnew 0) chain: E, M and W forwards to D, E and M
        add(f_jal(),          0, 0, 0, 0, 0, 0);
        add(f_alu(12, 0, 31), 0, 0, 1, 0, 0, 0);
        add(f_jr(31),         0, 2, 0, 0, 2, 0);
        add(f_alu(13, 31, 12),0, 3, 2, 3, 0, 1);
        add(f_nop(),          0, 0, 0, 0, 3, 0);
        add(f_nop(),          0, 0, 0, 0, 0, 0);
        add(f_nop(),          0, 0, 0, 0, 0, 0);
        // lw $8 -> addu rt=$8: stall on the rt operand
        add(f_lw(8, 29),      0, 0, 0, 0, 0, 0);
        add(f_alu(9, 0, 8),   1, 0, 0, 0, 0, 0);
        add(f_alu(9, 0, 8),   0, 0, 0, 0, 0, 0);
        add(f_nop(),          0, 0, 0, 0, 3, 0);
        add(f_nop(),          0, 0, 0, 0, 0, 0);
        add(f_nop(),          0, 0, 0, 0, 0, 0);
        // lw $8 -> sw $8: rt Tuse 2 equals Tnew 2, no stall; M blocks W in E
        add(f_lw(8, 29),      0, 0, 0, 0, 0, 0);
        add(f_sw(8, 29),      0, 0, 0, 0, 0, 0);
        add(f_nop(),          0, 0, 0, 0, 0, 0);
        add(f_nop(),          0, 0, 0, 0, 0, 1);
        add(f_nop(),          0, 0, 0, 0, 0, 0);

        // reset held from time zero
        reset = 1'b1;
        drive(f_alu(10, 8, 9));
        #2;
        chk_all("reset_hold", zero);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(f_nop());
        #1;
        chk_all("reset_release", zero);
        @(posedge clk);
        #1;

        for (int i = 0; i < tab.size(); i++) begin
            drive(tab[i].d);
            sb.push_back(tab[i].e);
            @(negedge clk);
            exp_o = sb.pop_front();
            chk_all($sformatf("vec%0d", i), exp_o);
            @(posedge clk);
            #1;
        end

        // reset asserted mid-operation between clock edges
        drive(f_lw(8, 29));
        @(posedge clk);
        #1;
        drive(f_alu(10, 8, 9));
        #1;
        chk_all("midrst_before", mk_out(1, 0, 0, 0, 0, 0));
        #1;
        reset = 1'b1;
        #1;
        chk_all("midrst_async", zero);
        #2;
        reset = 1'b0;
        #1;
        chk_all("midrst_released", zero);
        @(posedge clk);
        #1;
        drive(f_nop());
        #1;
        chk_all("midrst_after1", zero);
        @(posedge clk);
        #2;
        chk_all("midrst_after2", zero);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_hazard_ctrl
`default_nettype wire
